// File: rtl/posit_stream_min_reduce.sv
// posit_stream_min_reduce: folds a valid/ready posit stream into its minimum, first index and beat count.
module posit_stream_min_reduce #(
  parameter int WIDTH   = 8,
  parameter int ES      = 1,
  parameter int MAX_LEN = 256,
  parameter int IDX_W   = $clog2(MAX_LEN),
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  input  logic             inLast,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData,
  output logic [IDX_W-1:0] outIndex,
  output logic [CNT_W-1:0] outCount,
  output logic             outOverflow
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, stateNext;
  logic accept, first, less, cntSat;
  if (ES >= WIDTH) begin : gBadEs
    $error("ES must be smaller than WIDTH");
  end
  assign inReady  = (state != HOLD) | outReady;
  assign outValid = state == HOLD;
  assign accept   = inValid & inReady;
  assign first    = accept & (state != ACCUM);
  // NaR is 1000..0, the most negative two's-complement value, so a signed compare handles it.
  assign less     = $signed(inData) < $signed(outData);
  assign cntSat   = outCount == CNT_W'(MAX_LEN);
  always_comb begin
    stateNext = state;
    stateNext = accept ? (inLast ? HOLD : ACCUM)
              : (state == HOLD && outReady) ? IDLE : state;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      outData     <= '0;
      outIndex    <= '0;
      outCount    <= '0;
      outOverflow <= 1'b0;
    end else begin
      state <= stateNext;
      if (first) begin
        outData     <= inData;
        outIndex    <= '0;
        outCount    <= CNT_W'(1);
        outOverflow <= 1'b0;
      end else if (accept) begin
        if (less) begin
          outData  <= inData;
          outIndex <= cntSat ? IDX_W'(MAX_LEN - 1) : IDX_W'(outCount);
        end
        if (cntSat) outOverflow <= 1'b1;
        else outCount <= outCount + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_posit_stream_min_reduce.sv
// tb_posit_stream_min_reduce: table vectors, corner sequences and random streams against a scan-based model.
module tb_posit_stream_min_reduce;
  localparam int MAX_LEN = 4;
  logic clock = 0, reset = 1;
  logic inValid = 0, inReady, inLast = 0, outValid, outReady = 0, outOverflow;
  logic [7:0] inData = 0, outData;
  logic [1:0] outIndex;
  logic [2:0] outCount;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] i;
    logic [2:0] c;
    logic       o;
  } res_t;

  typedef struct {
    logic [0:5][7:0] d;
    int              len;
    res_t            exp;
  } vec_t;

  logic [7:0] streamQ[$];
  res_t resQ[$];
  vec_t vecs[7];

  posit_stream_min_reduce #(.WIDTH(8), .ES(1), .MAX_LEN(MAX_LEN)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady), .inData(inData),
    .inLast(inLast), .outValid(outValid), .outReady(outReady), .outData(outData),
    .outIndex(outIndex), .outCount(outCount), .outOverflow(outOverflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Whole-stream reference: scan for the smallest signed value, first occurrence wins.
  function automatic res_t model(input logic [7:0] q[$]);
    res_t r;
    int mi = 0;
    for (int i = 1; i < q.size(); i++)
      if ($signed(q[i]) < $signed(q[mi])) mi = i;
    r.d = q[mi];
    r.i = 2'(mi > MAX_LEN - 1 ? MAX_LEN - 1 : mi);
    r.c = 3'(q.size() > MAX_LEN ? MAX_LEN : q.size());
    r.o = q.size() > MAX_LEN;
    return r;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (outValid && outReady) begin
        if (resQ.size() == 0) chk("sb_unexpected_result", 32'(outValid), 32'(0));
        else chk("sb_result", 32'({outData, outIndex, outCount, outOverflow}), 32'(resQ.pop_front()));
      end
      if (inValid && inReady) begin
        streamQ.push_back(inData);
        if (inLast) begin
          resQ.push_back(model(streamQ));
          streamQ.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sendBeat(input logic [7:0] d, input logic l);
    int n = 0;
    inValid = 1; inData = d; inLast = l;
    @(negedge clock);
    while (!inReady && n < 50) begin
      tick();
      outReady = 1;
      n++;
      @(negedge clock);
    end
    if (!inReady) chk("beat_timeout", 32'(inReady), 32'(1));
    tick();
    inValid = 0; inLast = 0;
  endtask

  task automatic chkOut(input string name, input res_t exp);
    chk({name, "_valid"}, 32'(outValid), 32'(1));
    chk({name, "_out"}, 32'({outData, outIndex, outCount, outOverflow}), 32'(exp));
  endtask

  initial begin
    vecs[0] = '{{8'h40, 8'h20, 8'hC0, 8'h00, 8'h00, 8'h00}, 4, '{8'hC0, 2'd2, 3'd4, 1'b0}};
    vecs[1] = '{{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1, '{8'h20, 2'd0, 3'd1, 1'b0}};
    vecs[2] = '{{8'h20, 8'h10, 8'h10, 8'h00, 8'h00, 8'h00}, 3, '{8'h10, 2'd1, 3'd3, 1'b0}};
    vecs[3] = '{{8'h40, 8'h80, 8'hC0, 8'h00, 8'h00, 8'h00}, 3, '{8'h80, 2'd1, 3'd3, 1'b0}};
    vecs[4] = '{{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h10}, 6, '{8'h10, 2'd3, 3'd4, 1'b1}};
    vecs[5] = '{{8'h7F, 8'h81, 8'h80, 8'h81, 8'h00, 8'h00}, 4, '{8'h80, 2'd2, 3'd4, 1'b0}};
    vecs[6] = '{{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00}, 5, '{8'h80, 2'd0, 3'd4, 1'b1}};

    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_valid", 32'(outValid), 32'(0));
    chk("rst_out", 32'({outData, outIndex, outCount, outOverflow}), 32'(0));
    chk("rst_ready", 32'(inReady), 32'(1));
    tick();

    foreach (vecs[v]) begin
      outReady = 0;
      for (int j = 0; j < vecs[v].len; j++) sendBeat(vecs[v].d[j], j == vecs[v].len - 1);
      @(negedge clock);
      chkOut($sformatf("vec%0d", v), vecs[v].exp);
      chk($sformatf("vec%0d_ready", v), 32'(inReady), 32'(0));
      tick();
      outReady = 1;
      tick();
      outReady = 0;
    end

    outReady = 1;
    sendBeat(8'h20, 1);
    @(negedge clock);
    chkOut("single", '{8'h20, 2'd0, 3'd1, 1'b0});
    @(negedge clock);
    chk("single_idle", 32'(outValid), 32'(0));
    tick();

    outReady = 0;
    sendBeat(8'h60, 0);
    sendBeat(8'h30, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chkOut("bp_hold", '{8'h30, 2'd1, 3'd2, 1'b0});
      chk("bp_ready", 32'(inReady), 32'(0));
    end
    tick();
    outReady = 1;
    sendBeat(8'h30, 0);
    @(negedge clock);
    chk("b2b_consumed", 32'(outValid), 32'(0));
    tick();
    sendBeat(8'h70, 1);
    @(negedge clock);
    chkOut("b2b_new", '{8'h30, 2'd0, 3'd2, 1'b0});
    tick();

    sendBeat(8'h10, 0);
    sendBeat(8'h20, 0);
    #2 reset = 1;
    streamQ.delete();
    resQ.delete();
    #3 reset = 0;
    @(negedge clock);
    chk("midrst_valid", 32'(outValid), 32'(0));
    chk("midrst_out", 32'({outData, outIndex, outCount, outOverflow}), 32'(0));
    chk("midrst_ready", 32'(inReady), 32'(1));
    tick();
    sendBeat(8'h50, 1);
    @(negedge clock);
    chkOut("after_rst", '{8'h50, 2'd0, 3'd1, 1'b0});
    tick();

    for (int s = 0; s < 40; s++) begin
      int len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        logic [7:0] d;
        case ($urandom_range(0, 5))
          0: d = 8'h80;
          1: d = 8'h10;
          2: d = 8'hF0;
          3: d = 8'h7F;
          default: d = 8'($urandom);
        endcase
        outReady = $urandom_range(0, 3) != 0;
        repeat ($urandom_range(0, 2)) tick();
        sendBeat(d, j == len - 1);
      end
    end
    outReady = 1;
    repeat (4) tick();
    chk("drain_results", 32'(resQ.size()), 32'(0));
    chk("drain_stream", 32'(streamQ.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
